// File: rtl/wh_out_port_alloc.sv
// Wormhole output-port allocator: round-robin head arbitration, then the link stays locked to the winner until its tail transfers.
// Optional lock timeout with a sticky error flag is built when WH_OUT_ALLOC_TIMEOUT_EN is defined.
module wh_out_port_alloc #(
    parameter int N_INPUTS    = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [N_INPUTS-1:0]         req_i,
    input  logic [N_INPUTS-1:0]         head_i,
    input  logic [N_INPUTS-1:0]         tail_i,
    input  logic                        out_ready_i,
    output logic [N_INPUTS-1:0]         grant_o,
    output logic                        out_valid_o,
    output logic                        locked_o,
    output logic [$clog2(N_INPUTS)-1:0] owner_o,
    output logic                        err_o
);

    localparam int PW = $clog2(N_INPUTS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Elaboration-time sanity check on the configuration.
    if (N_INPUTS < 2 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("wh_out_port_alloc: N_INPUTS and TIMEOUT_CYC must both be at least 2");
    end

    function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] x);
        logic [PW-1:0] r;
        if (x == PW'(N_INPUTS - 1)) begin
            r = {PW{1'b0}};
        end else begin
            r = x + PW'(1);
        end
        return r;
    endfunction

    function automatic logic [N_INPUTS-1:0] onehot(input logic [PW-1:0] idx);
        logic [N_INPUTS-1:0] v;
        v      = {N_INPUTS{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t              state_r, state_n;
    logic [PW-1:0]       ptr_r, ptr_n;
    logic [PW-1:0]       owner_r, owner_n;
    logic [N_INPUTS-1:0] eligible_s;
    logic [N_INPUTS-1:0] grant_s;
    logic                valid_s;
    logic                xfer_s;
    logic                win_found_s;
    logic [PW-1:0]       win_idx_s;
    logic [PW-1:0]       scan_idx_s;

`ifdef WH_OUT_ALLOC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0]       stall_cnt_r, stall_cnt_n;
    logic                timeout_s;
    logic                err_r, err_n;
`endif

    assign eligible_s = req_i & head_i;

    // Round-robin search from ptr for the first input presenting a head flit.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = ptr_r;
        scan_idx_s  = ptr_r;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (!win_found_s && eligible_s[scan_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = scan_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
            scan_idx_s = inc_mod(scan_idx_s);
        end
    end

    // Grant / valid decode; held at zero while reset is asserted.
    always_comb begin
        grant_s = {N_INPUTS{1'b0}};
        valid_s = 1'b0;
        if (arst) begin
            grant_s = {N_INPUTS{1'b0}};
            valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        grant_s = onehot(win_idx_s);
                        valid_s = 1'b1;
                    end else begin
                        grant_s = {N_INPUTS{1'b0}};
                        valid_s = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    // The owner keeps the mux even through bubbles.
                    grant_s = onehot(owner_r);
                    valid_s = req_i[owner_r];
                end
                default: begin
                    grant_s = {N_INPUTS{1'b0}};
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    assign xfer_s = valid_s & out_ready_i;

    // Next-state logic for the lock FSM, round-robin pointer and owner.
    always_comb begin
        state_n = state_r;
        ptr_n   = ptr_r;
        owner_n = owner_r;
`ifdef WH_OUT_ALLOC_TIMEOUT_EN
        timeout_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    owner_n = win_idx_s;
                    if (tail_i[win_idx_s]) begin
                        ptr_n = inc_mod(win_idx_s);
                    end else begin
                        state_n = ST_LOCKED;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (xfer_s) begin
                    if (tail_i[owner_r]) begin
                        state_n = ST_IDLE;
                        ptr_n   = inc_mod(owner_r);
                    end else begin
                        state_n = ST_LOCKED;
                    end
                end else begin
`ifdef WH_OUT_ALLOC_TIMEOUT_EN
                    if (stall_cnt_r == CW'(TIMEOUT_CYC - 1)) begin
                        timeout_s = 1'b1;
                        state_n   = ST_IDLE;
                        ptr_n     = inc_mod(owner_r);
                    end else begin
                        timeout_s = 1'b0;
                    end
`else
                    state_n = ST_LOCKED;
`endif
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM, pointer and owner registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r <= ST_IDLE;
            ptr_r   <= {PW{1'b0}};
            owner_r <= {PW{1'b0}};
        end else begin
            state_r <= state_n;
            ptr_r   <= ptr_n;
            owner_r <= owner_n;
        end
    end

`ifdef WH_OUT_ALLOC_TIMEOUT_EN
    // Stall counter: only advances on LOCKED cycles without a transfer.
    always_comb begin
        stall_cnt_n = {CW{1'b0}};
        err_n       = err_r | timeout_s;
        if (state_r == ST_LOCKED && !xfer_s && !timeout_s) begin
            stall_cnt_n = stall_cnt_r + CW'(1);
        end else begin
            stall_cnt_n = {CW{1'b0}};
        end
    end

    // Stall counter and sticky error registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt_r <= {CW{1'b0}};
            err_r       <= 1'b0;
        end else begin
            stall_cnt_r <= stall_cnt_n;
            err_r       <= err_n;
        end
    end

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

    assign grant_o     = grant_s;
    assign out_valid_o = valid_s;
    assign locked_o    = (state_r == ST_LOCKED);
    assign owner_o     = owner_r;

endmodule

// File: tb/tb_wh_out_port_alloc.sv
// Self-checking bench for wh_out_port_alloc: directed steps then random traffic against a packet-level reference model.
module tb_wh_out_port_alloc;

    localparam int NI = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic [NI-1:0] req = '0, head = '0, tail = '0;
    logic          ready = 1'b0;
    logic [NI-1:0] grant;
    logic          valid, locked, err;
    logic [1:0]    owner;

    int checks = 0;
    int failures = 0;

    // reference model state (packet-level view of the link)
    bit m_rst = 1'b1;
    bit m_locked = 1'b0;
    bit m_err = 1'b0;
    int m_owner = 0;
    int m_ptr = 0;
    int m_stall = 0;

    always #5 clk = ~clk;

    wh_out_port_alloc #(.N_INPUTS(NI), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .arst(arst), .req_i(req), .head_i(head), .tail_i(tail),
        .out_ready_i(ready), .grant_o(grant), .out_valid_o(valid),
        .locked_o(locked), .owner_o(owner), .err_o(err)
    );

    function automatic void model_reset();
        m_rst = 1'b1; m_locked = 1'b0; m_err = 1'b0;
        m_owner = 0; m_ptr = 0; m_stall = 0;
    endfunction

    function automatic void model_out(output logic [NI-1:0] g, output logic v, output int w);
        g = '0; v = 1'b0; w = -1;
        if (!m_rst) begin
            if (m_locked) begin
                g[m_owner] = 1'b1;
                v = req[m_owner];
                w = m_owner;
            end else begin
                for (int k = 0; k < NI; k++) begin
                    int i;
                    i = (m_ptr + k) % NI;
                    if (w < 0 && req[i] && head[i]) w = i;
                end
                if (w >= 0) begin
                    g[w] = 1'b1;
                    v = 1'b1;
                end
            end
        end
    endfunction

    function automatic void model_edge(input logic v, input int w);
        bit xfer;
        xfer = v && ready;
        if (!m_rst) begin
            if (m_locked) begin
                if (xfer) begin
                    m_stall = 0;
                    if (tail[m_owner]) begin
                        m_locked = 1'b0;
                        m_ptr = (m_owner + 1) % NI;
                    end
                end else begin
`ifdef WH_OUT_ALLOC_TIMEOUT_EN
                    if (m_stall == TO - 1) begin
                        m_err = 1'b1; m_locked = 1'b0; m_stall = 0;
                        m_ptr = (m_owner + 1) % NI;
                    end else begin
                        m_stall++;
                    end
`endif
                end
            end else begin
                m_stall = 0;
                if (xfer) begin
                    m_owner = w;
                    if (tail[w]) m_ptr = (w + 1) % NI;
                    else m_locked = 1'b1;
                end
            end
        end
    endfunction

    task automatic cycle(input bit rst, input logic [NI-1:0] r, input logic [NI-1:0] h,
                         input logic [NI-1:0] t, input logic rdy, input string tag,
                         input bit use_want, input logic [NI-1:0] want);
        logic [NI-1:0] g;
        logic v;
        int w;
        @(negedge clk);
        arst = rst; req = r; head = h; tail = t; ready = rdy;
        if (rst) model_reset();
        else m_rst = 1'b0;
        #1;
        model_out(g, v, w);
        checks++;
        assert (grant === g) else begin failures++; $error("FAIL %s grant got=%b exp=%b", tag, grant, g); end
        checks++;
        assert (valid === v) else begin failures++; $error("FAIL %s out_valid got=%b exp=%b", tag, valid, v); end
        checks++;
        assert (locked === m_locked) else begin failures++; $error("FAIL %s locked got=%b exp=%b", tag, locked, m_locked); end
        checks++;
        assert (owner === 2'(m_owner)) else begin failures++; $error("FAIL %s owner got=%0d exp=%0d", tag, owner, m_owner); end
        checks++;
        assert (err === m_err) else begin failures++; $error("FAIL %s err got=%b exp=%b", tag, err, m_err); end
        if (use_want) begin
            checks++;
            assert (grant === want) else begin failures++; $error("FAIL %s plan_grant got=%b exp=%b", tag, grant, want); end
        end
        @(posedge clk);
        model_edge(v, w);
    endtask

    initial begin
        logic [NI-1:0] rr_want [5];
        rr_want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // reset with every input requesting a head
        cycle(1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b1, "reset", 1'b1, 4'b0000);
        cycle(1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, "first_grant", 1'b1, 4'b0001);

        // round robin over single-flit packets
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b1, "rr", 1'b1, rr_want[i]);

        // move ptr to 2, then a 3-flit packet on input2 with input0 waiting
        cycle(1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b1, "ptr_to2", 1'b1, 4'b0010);
        cycle(1'b0, 4'b0101, 4'b0101, 4'b0000, 1'b1, "wh_head", 1'b1, 4'b0100);
        cycle(1'b0, 4'b0101, 4'b0001, 4'b0000, 1'b1, "wh_body", 1'b1, 4'b0100);
        cycle(1'b0, 4'b0101, 4'b0001, 4'b0100, 1'b1, "wh_tail", 1'b1, 4'b0100);
        cycle(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, "wh_next", 1'b1, 4'b0001);

        // backpressure during a lock on input1
        cycle(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, "bp_head", 1'b1, 4'b0010);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, "bp_stall", 1'b1, 4'b0010);
        cycle(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1, "bp_tail", 1'b1, 4'b0010);

        // owner bubble on input3 while others present heads
        cycle(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b1, "bub_head", 1'b1, 4'b1000);
        for (int i = 0; i < 2; i++)
            cycle(1'b0, 4'b0111, 4'b0111, 4'b0000, 1'b1, "bub_gap", 1'b1, 4'b1000);
        cycle(1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b1, "bub_tail", 1'b1, 4'b1000);

`ifdef WH_OUT_ALLOC_TIMEOUT_EN
        // lock on input0 then stall long enough to time out
        cycle(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, "to_head", 1'b1, 4'b0001);
        for (int i = 0; i < TO; i++)
            cycle(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, "to_stall", 1'b1, 4'b0001);
        cycle(1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b1, "to_after", 1'b1, 4'b0010);
        checks++;
        assert (err === 1'b1) else begin failures++; $error("FAIL to_err got=%b exp=1", err); end
        cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, "to_sticky", 1'b0, 4'b0000);
        cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, "to_clear", 1'b0, 4'b0000);
`endif

        // random traffic with occasional reset mid-packet
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 199) == 0), 4'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) != 0), "rand", 1'b0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
